// File: rtl/mem_access_stage.sv
// Memory-access stage: turns ALU results into lw/lb/sw/sb transactions over a req/ack
// data-memory port and returns exactly one writeback beat per accepted instruction.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_byte,
  input  logic        reg_write,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  // Handshake: an instruction moves when ex_valid & ex_ready are both high at a rising edge;
  // execute must hold its inputs until then, and nothing is sampled at any other time.
  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    lane;
  logic          byte_op;
  logic          store_op;
  logic          rw_q;
  logic [4:0]    rd_q;

  logic          accept;
  logic          mem_op;
  logic          misaligned;
  logic [7:0]    ld_byte;
  logic [31:0]   ld_data;

  assign ex_ready = (state == IDLE);
  assign accept   = ex_valid & ex_ready;

  always_comb begin
    mem_op     = mem_read | mem_write;
    misaligned = mem_op & ~mem_byte & (|alu_result[1:0]);
    ld_byte    = dmem_rdata[8*lane +: 8];
    ld_data    = byte_op ? {{24{ld_byte[7]}}, ld_byte} : dmem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lane         <= '0;
      byte_op      <= 1'b0;
      store_op     <= 1'b0;
      rw_q         <= 1'b0;
      rd_q         <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!mem_op) begin
              wb_valid <= 1'b1;
              wb_we    <= reg_write;
              wb_rd    <= rd_addr;
              wb_data  <= alu_result;
            end else if (misaligned) begin
              wb_valid     <= 1'b1;
              wb_we        <= 1'b0;
              wb_rd        <= rd_addr;
              wb_data      <= '0;
              misalign_err <= 1'b1;
            end else begin
              // Both read and write set is an illegal encoding and is handled as a load.
              state      <= WAIT_ACK;
              cnt        <= '0;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write & ~mem_read;
              dmem_addr  <= alu_result & ~32'h3;
              dmem_be    <= mem_byte ? (4'b0001 << alu_result[1:0]) : 4'hF;
              dmem_wdata <= mem_byte ? {4{store_data[7:0]}} : store_data;
              lane       <= alu_result[1:0];
              byte_op    <= mem_byte;
              store_op   <= mem_write & ~mem_read;
              rw_q       <= reg_write;
              rd_q       <= rd_addr;
            end
          end
        end
        WAIT_ACK: begin
          if (dmem_ack) begin
            // An ack on the limit cycle still completes the access normally.
            state    <= IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_we    <= store_op ? 1'b0 : rw_q;
            wb_rd    <= rd_q;
            wb_data  <= store_op ? 32'h0 : ld_data;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE;
            dmem_req    <= 1'b0;
            timeout_err <= 1'b1;
            wb_valid    <= 1'b1;
            wb_we       <= 1'b0;
            wb_rd       <= rd_q;
            wb_data     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
